timestamp_snap_arbiter: RTL and testbench

//  Shares one 8-bit timestamp byte bus between CHN timestamp_fifo instances (one per sensor/event channel).

---
 rtl/timestamp_pkg.sv | 20 ++
 rtl/ts_rr_arbiter.sv | 37 +++
 rtl/timestamp_snap_arbiter.sv | 116 +++++++++++
 tb/tb_timestamp_snap_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timestamp_pkg.sv
// Shared types for the timestamp snapshot arbiter.
// Holds FSM encoding and the captured-timestamp layout.
package timestamp_pkg;

  localparam int TS_BYTES = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_SEND,
    ST_GAP
  } ts_state_t;

  typedef struct packed {
    logic [31:0] sec;
    logic [11:0] rsvd;
    logic [19:0] usec;
  } ts_snap_t;

endpackage

// File: rtl/ts_rr_arbiter.sv
// Combinational round-robin picker.
// Grants the first requester at or after ptr, wrapping.
module ts_rr_arbiter #(
  parameter int CHN = 4,
  localparam int PW = (CHN > 1) ? $clog2(CHN) : 1
) (
  input  logic [CHN-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [CHN-1:0] grant,
  output logic [PW-1:0]  idx
);

  logic [2*CHN-1:0] dbl;
  logic [CHN-1:0]   rot;
  logic [PW-1:0]    off;
  logic [PW:0]      sum;
  logic             found;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[CHN-1:0];
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < CHN; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = PW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PW+1)'(CHN))
      sum = sum - (PW+1)'(CHN);
    idx   = sum[PW-1:0];
    grant = found ? (CHN'(1) << idx) : '0;
  end

endmodule

// File: rtl/timestamp_snap_arbiter.sv
// Snapshots RTC per channel and serialises pending
// snapshots round-robin onto one byte bus.
module timestamp_snap_arbiter
  import timestamp_pkg::*;
#(
  parameter int CHN = 4,
  parameter int GAP = 4
) (
  input  logic           sclk,
  input  logic           rst_n,
  input  logic [31:0]    ts_sec,
  input  logic [19:0]    ts_usec,
  input  logic [CHN-1:0] ts_req,
  input  logic [CHN-1:0] overrun_clr,
  output logic [CHN-1:0] ts_pre_stb,
  output logic [7:0]     ts_data,
  output logic           busy,
  output logic [CHN-1:0] pending,
  output logic [CHN-1:0] overrun
);

  localparam int PW = (CHN > 1) ? $clog2(CHN) : 1;
  localparam int GW = $clog2(GAP + 1);

  ts_state_t      state;
  ts_snap_t       snap [CHN];
  logic [63:0]    sh;
  logic [2:0]     cnt;
  logic [GW-1:0]  gcnt;
  logic [PW-1:0]  rr_ptr;
  logic [CHN-1:0] gnt;
  logic [CHN-1:0] take;
  logic [PW-1:0]  gidx;
  logic           gap_done;
  logic           grant_en;

  ts_rr_arbiter #(.CHN(CHN)) u_arb (
    .req   (pending),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gidx)
  );

  assign gap_done = (state == ST_GAP) && (gcnt == GW'(GAP));
  assign grant_en = (|pending) && (state == ST_IDLE || gap_done);
  assign take     = grant_en ? gnt : '0;
  assign busy     = (state != ST_IDLE);

  // A request on the grant edge refills the slot being drained.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
      for (int c = 0; c < CHN; c++)
        snap[c] <= '0;
    end else begin
      for (int c = 0; c < CHN; c++) begin
        if (ts_req[c] && (!pending[c] || take[c])) begin
          snap[c]    <= '{sec: ts_sec, rsvd: 12'h000, usec: ts_usec};
          pending[c] <= 1'b1;
        end else if (take[c]) begin
          pending[c] <= 1'b0;
        end
        overrun[c] <= (ts_req[c] && pending[c] && !take[c])
                    || (overrun[c] && !overrun_clr[c]);
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sh         <= '0;
      cnt        <= '0;
      gcnt       <= '0;
      rr_ptr     <= '0;
      ts_pre_stb <= '0;
      ts_data    <= '0;
    end else begin
      ts_pre_stb <= '0;
      ts_data    <= '0;
      if (grant_en) begin
        state      <= ST_PRE;
        ts_pre_stb <= gnt;
        sh         <= {12'h000, snap[gidx].usec, snap[gidx].sec};
        rr_ptr     <= (gidx == PW'(CHN-1)) ? '0 : gidx + 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: ;
          ST_PRE: begin
            state   <= ST_SEND;
            ts_data <= sh[7:0];
            sh      <= sh >> 8;
            cnt     <= '0;
          end
          ST_SEND: begin
            if (cnt == 3'(TS_BYTES-1)) begin
              state <= ST_GAP;
              gcnt  <= GW'(1);
            end else begin
              ts_data <= sh[7:0];
              sh      <= sh >> 8;
              cnt     <= cnt + 3'd1;
            end
          end
          ST_GAP: begin
            if (gap_done) state <= ST_IDLE;
            else          gcnt  <= gcnt + 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timestamp_snap_arbiter.sv
// Directed bench for timestamp_snap_arbiter.
// Hand-computed bytes and cycle positions.
module tb_timestamp_snap_arbiter;

  logic        sclk;
  logic        rst_n;
  logic [31:0] ts_sec;
  logic [19:0] ts_usec;
  logic [3:0]  ts_req;
  logic [3:0]  overrun_clr;
  logic [3:0]  ts_pre_stb;
  logic [7:0]  ts_data;
  logic        busy;
  logic [3:0]  pending;
  logic [3:0]  overrun;

  int total = 0;
  int bad   = 0;
  int n;

  timestamp_snap_arbiter #(.CHN(4), .GAP(4)) dut (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .ts_sec      (ts_sec),
    .ts_usec     (ts_usec),
    .ts_req      (ts_req),
    .overrun_clr (overrun_clr),
    .ts_pre_stb  (ts_pre_stb),
    .ts_data     (ts_data),
    .busy        (busy),
    .pending     (pending),
    .overrun     (overrun)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] s,
                                          input logic [19:0] u,
                                          input int k);
    case (k)
      0: return s[7:0];
      1: return s[15:8];
      2: return s[23:16];
      3: return s[31:24];
      4: return u[7:0];
      5: return u[15:8];
      6: return {4'b0, u[19:16]};
      default: return 8'h00;
    endcase
  endfunction

  // Current cycle must be the pre_stb cycle; ends on the u3 cycle.
  task automatic expect_burst(input logic [3:0] g,
                              input logic [31:0] s,
                              input logic [19:0] u);
    chk("pre_stb", ts_pre_stb, g);
    chk("pre_data", ts_data, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("byte%0d", k), ts_data, exp_byte(s, u, k));
      chk($sformatf("stb%0d", k), ts_pre_stb, 0);
    end
  endtask

  task automatic wait_pre(output int cnt);
    cnt = 0;
    while (ts_pre_stb == 4'b0 && cnt < 40) begin
      step();
      cnt++;
    end
    chk("pre_wait_in_budget", cnt < 40, 1);
  endtask

  task automatic do_reset();
    ts_req      = '0;
    overrun_clr = '0;
    rst_n       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    ts_sec      = '0;
    ts_usec     = '0;
    ts_req      = '0;
    overrun_clr = '0;
    step();
    chk("rst_out", {ts_pre_stb, ts_data, busy, pending, overrun}, 0);
    step();
    rst_n = 1'b1;

    // 1: single request on ch0
    ts_sec  = 32'h12345678;
    ts_usec = 20'h9ABCD;
    ts_req  = 4'b0001;
    step();
    ts_req = '0;
    chk("t1_pend", pending, 4'b0001);
    chk("t1_c1stb", ts_pre_stb, 0);
    step();
    chk("t1_pend_clr", pending, 0);
    chk("t1_busy", busy, 1);
    expect_burst(4'b0001, 32'h12345678, 20'h9ABCD);
    chk("t1_u3", ts_data, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_gap_busy", busy, 1);
      chk("t1_gap_data", ts_data, 0);
    end
    step();
    chk("t1_idle", busy, 0);

    // 2: simultaneous ch0,ch1,ch3
    do_reset();
    ts_sec  = 32'hA5A50001;
    ts_usec = 20'h00102;
    ts_req  = 4'b1011;
    step();
    ts_req = '0;
    chk("t2_pend", pending, 4'b1011);
    step();
    expect_burst(4'b0001, 32'hA5A50001, 20'h00102);
    wait_pre(n);
    chk("t2_space1", n, 5);
    expect_burst(4'b0010, 32'hA5A50001, 20'h00102);
    wait_pre(n);
    chk("t2_space2", n, 5);
    expect_burst(4'b1000, 32'hA5A50001, 20'h00102);

    // 3: round-robin wrap after ch2
    do_reset();
    ts_sec  = 32'd1;
    ts_usec = 20'd2;
    ts_req  = 4'b0100;
    step();
    ts_req = '0;
    step();
    chk("t3_pre2", ts_pre_stb, 4'b0100);
    step();
    ts_sec  = 32'hCAFEF00D;
    ts_usec = 20'hFFFFF;
    ts_req  = 4'b0101;
    step();
    ts_req = '0;
    chk("t3_pend", pending, 4'b0101);
    wait_pre(n);
    chk("t3_wait", n, 11);
    expect_burst(4'b0001, 32'hCAFEF00D, 20'hFFFFF);
    wait_pre(n);
    expect_burst(4'b0100, 32'hCAFEF00D, 20'hFFFFF);

    // 4: overrun on ch1
    do_reset();
    ts_sec  = 32'd10;
    ts_usec = 20'd20;
    ts_req  = 4'b0001;
    step();
    ts_req = '0;
    step();
    chk("t4_pre0", ts_pre_stb, 4'b0001);
    ts_sec  = 32'h11111111;
    ts_usec = 20'h22222;
    ts_req  = 4'b0010;
    step();
    chk("t4_no_ovr", overrun, 0);
    ts_sec  = 32'h33333333;
    ts_usec = 20'h44444;
    ts_req  = 4'b0010;
    step();
    ts_req = '0;
    chk("t4_ovr", overrun, 4'b0010);
    chk("t4_pend", pending, 4'b0010);
    wait_pre(n);
    expect_burst(4'b0010, 32'h11111111, 20'h22222);
    overrun_clr = 4'b0010;
    step();
    overrun_clr = '0;
    chk("t4_clr", overrun, 0);
    ts_req = 4'b0010;
    step();
    chk("t4_pend2", pending, 4'b0010);
    overrun_clr = 4'b0010;
    ts_req      = 4'b0010;
    step();
    ts_req      = '0;
    overrun_clr = '0;
    chk("t4_setwins", overrun, 4'b0010);

    // 5: re-request on the grant edge
    do_reset();
    ts_sec  = 32'h01020304;
    ts_usec = 20'h50607;
    ts_req  = 4'b0001;
    step();
    ts_sec  = 32'h0A0B0C0D;
    ts_usec = 20'hE0F01;
    step();
    ts_req = '0;
    chk("t5_pend", pending, 4'b0001);
    chk("t5_ovr", overrun, 0);
    expect_burst(4'b0001, 32'h01020304, 20'h50607);
    wait_pre(n);
    chk("t5_space", n, 5);
    expect_burst(4'b0001, 32'h0A0B0C0D, 20'hE0F01);

    // 6: reset in the middle of a burst
    do_reset();
    ts_sec  = 32'hDEADBEEF;
    ts_usec = 20'h12345;
    ts_req  = 4'b1000;
    step();
    ts_req = '0;
    step();
    chk("t6_pre3", ts_pre_stb, 4'b1000);
    for (int i = 0; i < 5; i++) step();
    chk("t6_u0", ts_data, 8'h45);
    rst_n = 1'b0;
    #1;
    chk("t6_async", {ts_pre_stb, ts_data, busy, pending, overrun}, 0);
    #20;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_quiet", {ts_pre_stb, ts_data, busy, pending}, 0);
    end
    ts_req = 4'b0100;
    step();
    ts_req = '0;
    wait_pre(n);
    chk("t6_alive", ts_pre_stb, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
